// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
package pc_seq_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [1:0]        ALIGN_MASK       = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run/stall/done/fault sequencing for the single-cycle core,
// with saturating cycle and retired-instruction counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [ADDR_W-1:0] next_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              exec_valid,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retired_count
);

  state_t state;
  logic   in_run;
  logic   at_end;
  logic   misaligned;
  logic   start_run;

  assign in_run     = (state == ST_RUN);
  assign at_end     = (pc_addr == end_addr);
  assign misaligned = ((next_addr[1:0] & ALIGN_MASK) != 2'b00);
  assign start_run  = start && !in_run;

  // End-of-program wins over stall, stall wins over a misaligned target.
  assign exec_valid = in_run && !at_end && !stall && !misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc_addr <= RESET_PC;
      busy    <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (at_end) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!stall && misaligned) begin
            // PC stays on the instruction that produced the bad target.
            state <= ST_FAULT;
            busy  <= 1'b0;
            fault <= 1'b1;
          end else if (!stall) begin
            pc_addr <= next_addr;
          end
        end
        ST_IDLE, ST_DONE, ST_FAULT: begin
          if (start) begin
            state   <= ST_RUN;
            pc_addr <= RESET_PC;
            busy    <= 1'b1;
            done    <= 1'b0;
            fault   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          fault <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_run),
    .inc   (in_run),
    .count (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_run),
    .inc   (exec_valid),
    .count (retired_count)
  );

endmodule
